// File: rtl/lm96570_spi_shifter.sv
// -----------------------------------------------------------------------------
// lm96570_spi_shifter
//
// Serial transmit/receive engine for the LM96570 beamformer configuration port.
// A start pulse captures a frame length (clamped to DATA_W) and a parallel
// transmit word. The frame is then shifted out on spi_sclk/spi_sdi while
// spi_sdo is captured into rx_data. Finally spi_sle is pulsed to latch the
// frame, and done pulses for one cycle.
//
// Optional build macro: LM96570_SPI_MSB_FIRST_EN
//   defined   : bits go out from tx_data[N-1] down to tx_data[0]. The last bit
//               received lands in rx_data[0].
//   undefined : LSB-first. tx_data[0] goes out first, and the k-th received bit
//               lands in rx_data[k].
//   Timing is the same in both builds.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        single-cycle frame request (ignored unless idle)
//   num_of_bits  frame length in bits (clamped to DATA_W)
//   tx_data      frame payload
//   busy         high while a frame is in progress
//   done         one-cycle completion pulse
//   rx_data      bits captured from spi_sdo
//   spi_sclk     serial clock out
//   spi_sdi      serial data out
//   spi_sdo      serial readback in
//   spi_sle      latch enable out
//
// Handshake: start is only honoured in IDLE. Nothing is queued while busy or
// while done is high. done marks the end of the frame, and rx_data holds its
// value until the next accepted start.
// -----------------------------------------------------------------------------
module lm96570_spi_shifter #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 4,
  parameter int NBITS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NBITS_W-1:0] num_of_bits,
  input  logic [DATA_W-1:0]  tx_data,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rx_data,
  output logic               spi_sclk,
  output logic               spi_sdi,
  input  logic               spi_sdo,
  output logic               spi_sle
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [NBITS_W:0]   DATA_W_N = (NBITS_W + 1)'(DATA_W);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  tx_sh;    // remaining bits; next bit sits at the output end
  logic [NBITS_W:0]   n_q;      // captured, clamped frame length
  logic [NBITS_W:0]   bit_cnt;  // index of the bit currently on spi_sdi
  logic [DIV_W-1:0]   div_cnt;  // half-period counter, CLK_DIV-1 down to 0

  logic [NBITS_W:0]   n_req;
  logic               first_bit;
  logic [DATA_W-1:0]  tx_rest;
  logic               next_bit;
  logic [DATA_W-1:0]  tx_sh_next;
  logic [DATA_W-1:0]  rx_shift;
  logic [DATA_W-1:0]  rx_final;
  logic               last_bit;

  // The count is compared one bit wider so that DATA_W itself is representable.
  always_comb begin
    n_req = ({1'b0, num_of_bits} > DATA_W_N) ? DATA_W_N : {1'b0, num_of_bits};
  end

  assign last_bit = ((bit_cnt + 1'b1) == n_q);

`ifdef LM96570_SPI_MSB_FIRST_EN
  // Left-align the frame so that bit N-1 sits at the MSB, then shift left.
  logic [DATA_W-1:0] tx_aligned;
  always_comb begin
    tx_aligned = tx_data << (DATA_W_N - n_req);
    first_bit  = tx_aligned[DATA_W-1];
    tx_rest    = tx_aligned << 1;
    next_bit   = tx_sh[DATA_W-1];
    tx_sh_next = tx_sh << 1;
    // Shifting in at the LSB leaves the first bit at N-1 and the last at 0.
    rx_shift   = {rx_data[DATA_W-2:0], spi_sdo};
    rx_final   = rx_data;
  end
`else
  always_comb begin
    first_bit  = tx_data[0];
    tx_rest    = tx_data >> 1;
    next_bit   = tx_sh[0];
    tx_sh_next = tx_sh >> 1;
    // Shift in at the MSB. Once the frame ends, right-align so that the k-th
    // bit lands in rx_data[k].
    rx_shift   = {spi_sdo, rx_data[DATA_W-1:1]};
    rx_final   = rx_data >> (DATA_W_N - n_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_sdi  <= 1'b0;
      spi_sle  <= 1'b0;
      rx_data  <= '0;
      tx_sh    <= '0;
      n_q      <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= tx_rest;
            n_q     <= n_req;
            rx_data <= '0;
            bit_cnt <= '0;
            div_cnt <= DIV_LOAD;
            if (n_req == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= SHIFT_LO;
              busy    <= 1'b1;
              spi_sdi <= first_bit;
            end
          end
        end

        SHIFT_LO: begin
          if (div_cnt == '0) begin
            state    <= SHIFT_HI;
            spi_sclk <= 1'b1;
            div_cnt  <= DIV_LOAD;
            // spi_sdo is captured on the rising SCLK edge.
            rx_data  <= rx_shift;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_cnt == '0) begin
            spi_sclk <= 1'b0;
            div_cnt  <= DIV_LOAD;
            if (last_bit) begin
              state   <= LATCH;
              spi_sdi <= 1'b0;
              spi_sle <= 1'b1;
              rx_data <= rx_final;
            end else begin
              state   <= SHIFT_LO;
              bit_cnt <= bit_cnt + 1'b1;
              spi_sdi <= next_bit;
              tx_sh   <= tx_sh_next;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        LATCH: begin
          if (div_cnt == '0) begin
            state   <= DONE;
            spi_sle <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
